reg_file: RTL and testbench
===========================

# reg_file

Y86-64 program register file for the SEQ core. It holds the fifteen architectural registers %rax–%r14. Decode reads two operands (valA, valB) combinationally from it. At the end of each instruction cycle it commits the ALU result (valE) and the memory result (valM) to their destinations. It sits downstream of the ALU, consuming valE, and upstream of the ALU, supplying its operands.

## Interface
Parameters:
- DATA_W, 64, register width
- RSP_INIT, 64'h0, value loaded into %rsp (ID 4) on reset

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  commit enable; low when the core is halted or stat != AOK; suppresses all writes
- srcA  input  4  read port A register ID; 4'hF = RNONE
- srcB  input  4  read port B register ID; 4'hF = RNONE
- valA  output  DATA_W  contents of srcA; 0 when srcA = RNONE
- valB  output  DATA_W  contents of srcB; 0 when srcB = RNONE
- dstE  input  4  write port E destination; RNONE = no write
- valE  input  DATA_W  ALU result to write at dstE
- dstM  input  4  write port M destination; RNONE = no write
- valM  input  DATA_W  memory data to write at dstM
- dbg_sel  input  4  debug read select
- dbg_val  output  DATA_W  contents of dbg_sel; 0 for RNONE

## Operation
- Storage is 15 registers × DATA_W, IDs 0–14. ID 15 (RNONE) is not storage: reads return 0 and writes are dropped.
- Reads are purely combinational from the current register state. There is no write-to-read bypass. A read of a register being written this cycle returns the old value, which matches SEQ semantics: the update happens at the cycle boundary.
- Write rules, evaluated on the rising clk edge when rst = 0 and en = 1:
  - dstE != RNONE → reg[dstE] ← valE
  - dstM != RNONE → reg[dstM] ← valM
  - dstE == dstM != RNONE → valM wins. This is the popq %rsp rule: %rsp ends with the popped value, not the incremented pointer.
  - Otherwise both writes occur in the same cycle.
- en = 0: no register changes, regardless of dstE/dstM.
- rst = 1 on an edge: every register ← 0, except %rsp ← RSP_INIT. Reset has priority over en and over any pending write, including a write to %rsp in the same cycle.
- Conditional moves are resolved upstream: decode drives dstE = RNONE when Cnd = 0. This block does no condition evaluation.
- Arithmetic: none. Values are stored and returned bit-exact at DATA_W. Signedness is irrelevant.

## Timing
- Read latency: 0 cycles (combinational from srcA/srcB/dbg_sel).
- Write latency: 1 edge. A value written at edge N is visible on valA/valB/dbg_val immediately after edge N.
- Reset values:
  - all registers 0 except %rsp = RSP_INIT
  - valA/valB/dbg_val reflect those values combinationally; 0 for RNONE selects
- Reset mid-program: a write presented in the reset cycle is lost. The first write after reset deasserts takes effect on the next edge.
- No handshake. The caller guarantees the dst/val inputs are stable before the edge.

## Structure
- Shared package y86_pkg holds:
  - RNONE = 4'hF
  - RRSP = 4'h4
  - register ID localparams RRAX..RR14
  - DATA_W default
- Same package is used by the decode and ALU-control logic.
- Single module; no sub-module required. Storage is an array of 15 registers, with one write-select per port decoded inline.
- Read muxes are shared logic for valA, valB and dbg_val, written as a function in the package: reg_read(id) returning 0 for RNONE.

## Test plan
- Reset: RSP_INIT=64'h200, assert rst one edge → dbg_val for IDs 0–14 all 0 except ID 4 = 64'h200; srcA=RNONE → valA=0.
- Single write/read: dstE=3, valE=64'hDEAD_BEEF, en=1, one edge → valA=64'hDEAD_BEEF with srcA=3. Before the edge, with dstE=3 and srcA=3, valA = old value 0 (no bypass).
- Dual write: dstE=1/valE=5, dstM=2/valM=7, one edge → reg1=5, reg2=7.
- Collision: dstE=dstM=4, valE=64'h208, valM=64'h1234 → reg4=64'h1234.
- Gating: en=0, dstE=6, valE=9 → reg6 unchanged. Then dstE=RNONE with en=1 → no register changes (check all 15 via dbg_sel).
- Reset priority: rst=1, en=1, dstE=4, valE=64'hFF in the same cycle → reg4=RSP_INIT. Writes resume on the first edge after rst drops.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: register IDs, data width and the register-read helper.
// Used by the register file as well as the decode and ALU-control logic.
package y86_pkg;

  localparam int DATA_W   = 64;
  localparam int NUM_REGS = 15;

  localparam logic [3:0] RRAX  = 4'h0;
  localparam logic [3:0] RRCX  = 4'h1;
  localparam logic [3:0] RRDX  = 4'h2;
  localparam logic [3:0] RRBX  = 4'h3;
  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RRBP  = 4'h5;
  localparam logic [3:0] RRSI  = 4'h6;
  localparam logic [3:0] RRDI  = 4'h7;
  localparam logic [3:0] RR8   = 4'h8;
  localparam logic [3:0] RR9   = 4'h9;
  localparam logic [3:0] RR10  = 4'hA;
  localparam logic [3:0] RR11  = 4'hB;
  localparam logic [3:0] RR12  = 4'hC;
  localparam logic [3:0] RR13  = 4'hD;
  localparam logic [3:0] RR14  = 4'hE;
  localparam logic [3:0] RNONE = 4'hF;

  typedef logic [DATA_W-1:0] word_t;
  typedef word_t             regs_t [NUM_REGS];

  // RNONE is not backed by storage, so it always reads as zero.
  function automatic word_t reg_read(input regs_t regs, input logic [3:0] id);
    if (id == RNONE) begin
      return '0;
    end
    return regs[id];
  endfunction

endpackage

// File: rtl/reg_file.sv
// Y86-64 SEQ program register file: fifteen registers, two combinational
// operand read ports plus a debug read port, and two write ports (E and M)
// committed on the rising clock edge.
module reg_file
  import y86_pkg::*;
#(
  parameter int                DATA_W   = y86_pkg::DATA_W,
  parameter logic [DATA_W-1:0] RSP_INIT = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [3:0]        srcA,
  input  logic [3:0]        srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  input  logic [3:0]        dstE,
  input  logic [DATA_W-1:0] valE,
  input  logic [3:0]        dstM,
  input  logic [DATA_W-1:0] valM,
  input  logic [3:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_val
);

  regs_t regs_q;
  regs_t regs_d;

  // Next register state: port M is checked first so it wins a same-register
  // collision with port E (popq %rsp leaves the popped value in %rsp).
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (en && (dstM == 4'(i))) begin
        regs_d[i] = word_t'(valM);
      end else if (en && (dstE == 4'(i))) begin
        regs_d[i] = word_t'(valE);
      end
    end
  end

  // Register storage; reset overrides every pending write, including to %rsp.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (4'(i) == RRSP) ? word_t'(RSP_INIT) : '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Combinational reads of the current state; no write-to-read bypass.
  always_comb begin
    valA    = DATA_W'(reg_read(regs_q, srcA));
    valB    = DATA_W'(reg_read(regs_q, srcB));
    dbg_val = DATA_W'(reg_read(regs_q, dbg_sel));
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: stimulus pushes expected read values into a
// scoreboard queue, a negedge monitor pops and compares them.
module tb_reg_file;

  localparam logic [63:0] RSP_INIT = 64'h200;
  localparam logic [3:0]  NONE     = 4'hF;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  srcA;
  logic [3:0]  srcB;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [3:0]  dstE;
  logic [63:0] valE;
  logic [3:0]  dstM;
  logic [63:0] valM;
  logic [3:0]  dbg_sel;
  logic [63:0] dbg_val;

  typedef struct {
    bit          chk;
    logic [3:0]  sa;
    logic [3:0]  sb;
    logic [3:0]  sd;
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] ed;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_x;
  logic [63:0] model [16];
  int          errors = 0;
  int          checks = 0;

  reg_file #(.DATA_W(64), .RSP_INIT(RSP_INIT)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .srcA    (srcA),
    .srcB    (srcB),
    .valA    (valA),
    .valB    (valB),
    .dstE    (dstE),
    .valE    (valE),
    .dstM    (dstM),
    .valM    (valM),
    .dbg_sel (dbg_sel),
    .dbg_val (dbg_val)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [3:0] id,
                              input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s id=%0d actual=%h required=%h", name, id, act, exp);
    end
  endtask

  // Monitor: compare DUT read ports against the oldest scoreboard entry.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_x = sb_q.pop_front();
      if (mon_x.chk) begin
        check_output("valA", mon_x.sa, valA, mon_x.ea);
        check_output("valB", mon_x.sb, valB, mon_x.eb);
        check_output("dbg_val", mon_x.sd, dbg_val, mon_x.ed);
      end
    end
  end

  // Drive one cycle, record the expected reads (pre-edge state), then apply
  // the architectural write rules to the reference model at the edge.
  task automatic apply_stimulus(input bit r, input bit e,
                                input logic [3:0] sa, input logic [3:0] sb,
                                input logic [3:0] sd,
                                input logic [3:0] de, input logic [63:0] ve,
                                input logic [3:0] dm, input logic [63:0] vm,
                                input bit chk);
    exp_t x;
    rst = r; en = e; srcA = sa; srcB = sb; dbg_sel = sd;
    dstE = de; valE = ve; dstM = dm; valM = vm;
    x.chk = chk; x.sa = sa; x.sb = sb; x.sd = sd;
    x.ea = model[sa]; x.eb = model[sb]; x.ed = model[sd];
    sb_q.push_back(x);
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 16; i++) model[i] = 64'h0;
      model[4] = RSP_INIT;
    end else if (e) begin
      if (de != NONE) model[de] = ve;
      if (dm != NONE) model[dm] = vm;
    end
    #1;
  endtask

  task automatic sweep_all(input bit e);
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(1'b0, e, NONE, 4'(15 - i), 4'(i),
                     NONE, {$urandom, $urandom}, NONE, {$urandom, $urandom}, 1'b1);
    end
  endtask

  initial begin
    logic [3:0]  de;
    logic [3:0]  dm;
    bit          r;
    bit          e;
    int          wait_cnt;

    for (int i = 0; i < 16; i++) model[i] = 64'h0;
    rst = 1'b1; en = 1'b0; srcA = NONE; srcB = NONE; dbg_sel = NONE;
    dstE = NONE; valE = '0; dstM = NONE; valM = '0;
    @(posedge clk); #1;

    // Reset, then sweep every ID through the debug port.
    apply_stimulus(1'b1, 1'b0, NONE, NONE, NONE, NONE, 64'h0, NONE, 64'h0, 1'b0);
    sweep_all(1'b0);

    // Single write: read in the write cycle returns the old value.
    apply_stimulus(1'b0, 1'b1, 4'd3, NONE, 4'd3, 4'd3, 64'hDEAD_BEEF, NONE, 64'h0, 1'b1);
    apply_stimulus(1'b0, 1'b1, 4'd3, 4'd3, NONE, NONE, 64'h0, NONE, 64'h0, 1'b1);

    // Dual write to different registers.
    apply_stimulus(1'b0, 1'b1, 4'd1, 4'd2, 4'd1, 4'd1, 64'd5, 4'd2, 64'd7, 1'b1);
    apply_stimulus(1'b0, 1'b1, 4'd1, 4'd2, 4'd2, NONE, 64'h0, NONE, 64'h0, 1'b1);

    // Collision on %rsp: valM must win.
    apply_stimulus(1'b0, 1'b1, 4'd4, NONE, 4'd4, 4'd4, 64'h208, 4'd4, 64'h1234, 1'b1);
    apply_stimulus(1'b0, 1'b1, 4'd4, 4'd4, 4'd4, NONE, 64'h0, NONE, 64'h0, 1'b1);

    // Gating: en low suppresses writes on both ports.
    apply_stimulus(1'b0, 1'b0, 4'd6, NONE, 4'd6, 4'd6, 64'd9, 4'd7, 64'd11, 1'b1);
    apply_stimulus(1'b0, 1'b1, 4'd6, 4'd7, 4'd6, NONE, 64'h0, NONE, 64'h0, 1'b1);

    // RNONE destinations with en high leave all registers unchanged.
    sweep_all(1'b1);

    // Reset priority over a same-cycle write, then writes resume.
    apply_stimulus(1'b1, 1'b1, 4'd4, NONE, 4'd4, 4'd4, 64'hFF, NONE, 64'h0, 1'b1);
    apply_stimulus(1'b0, 1'b1, 4'd4, 4'd3, 4'd4, 4'd4, 64'h55, NONE, 64'h0, 1'b1);
    apply_stimulus(1'b0, 1'b1, 4'd4, 4'd3, 4'd1, NONE, 64'h0, NONE, 64'h0, 1'b1);

    // Randomized traffic with occasional reset, gating and forced collisions.
    for (int n = 0; n < 400; n++) begin
      r  = ($urandom_range(0, 31) == 0);
      e  = ($urandom_range(0, 3) != 0);
      de = 4'($urandom_range(0, 15));
      dm = ($urandom_range(0, 5) == 0) ? de : 4'($urandom_range(0, 15));
      apply_stimulus(r, e, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15)), de, {$urandom, $urandom},
                     dm, {$urandom, $urandom}, 1'b1);
    end

    // Final full sweep of the register state.
    sweep_all(1'b0);

    // Let the monitor drain the scoreboard, bounded.
    wait_cnt = 0;
    while (sb_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain actual=%0d required=0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
